// File: rtl/fir_out_requant.sv
// fir_out_requant: decimates the FIR output by M, rounds/saturates it to
// W_O bits and buffers the results in a first-word fall-through FIFO.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   y          signed filter output sample (W_Y bits)
//   y_valid    y carries a new sample this cycle
//   m_data     signed requantised sample at FIFO head (0 when empty)
//   m_valid    m_data is valid
//   m_ready    downstream accepts m_data this cycle
//   clr_flags  synchronous clear of both sticky flags
//   sat_flag   sticky: a kept sample saturated
//   ovf_flag   sticky: a kept sample was dropped on a full FIFO
module fir_out_requant #(
   parameter int W_Y   = 10,
   parameter int W_O   = 4,
   parameter int SHIFT = 3,
   parameter int M     = 2,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic [W_Y-1:0] y,
   input  logic           y_valid,
   output logic [W_O-1:0] m_data,
   output logic           m_valid,
   input  logic           m_ready,
   input  logic           clr_flags,
   output logic           sat_flag,
   output logic           ovf_flag
);

   localparam int PW     = (M > 1) ? $clog2(M) : 1;
   localparam int AW     = $clog2(DEPTH);
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic [PW-1:0] PH_LAST  = PW'(M - 1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

   localparam logic signed [W_Y:0] RND =
      (W_Y + 1)'((SHIFT > 0) ? (1 << RND_SH) : 0);
   localparam logic signed [W_Y:0] MAXV =
      (W_Y + 1)'((1 << (W_O - 1)) - 1);
   localparam logic signed [W_Y:0] MINV = ~MAXV;

   localparam logic [W_O-1:0] MAXO = {1'b0, {(W_O - 1){1'b1}}};
   localparam logic [W_O-1:0] MINO = {1'b1, {(W_O - 1){1'b0}}};

   // ---------------------------------------------------------------
   // Decimation phase
   // ---------------------------------------------------------------
   logic [PW-1:0] phase;
   logic          keep;

   assign keep = y_valid && (phase == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase <= '0;
      end else if (y_valid) begin
         if (phase == PH_LAST) begin
            phase <= '0;
         end else begin
            phase <= phase + PW'(1);
         end
      end
   end

   // ---------------------------------------------------------------
   // Round half-up and saturate
   // ---------------------------------------------------------------
   // One guard bit keeps the rounding add from wrapping at +max.
   logic signed [W_Y:0] y_ext;
   logic signed [W_Y:0] t;
   logic signed [W_Y:0] r;
   logic                sat_hi;
   logic                sat_lo;
   logic [W_O-1:0]      q;

   assign y_ext  = $signed({y[W_Y-1], y});
   assign t      = y_ext + RND;
   assign r      = t >>> SHIFT;
   assign sat_hi = (r > MAXV);
   assign sat_lo = (r < MINV);

   always_comb begin
      q = r[W_O-1:0];
      unique case (1'b1)
         sat_hi:  q = MAXO;
         sat_lo:  q = MINO;
         default: q = r[W_O-1:0];
      endcase
   end

   // ---------------------------------------------------------------
   // One-entry stage between requantiser and FIFO
   // ---------------------------------------------------------------
   logic           stg_vld;
   logic [W_O-1:0] stg_data;
   logic           sat_ev;

   assign sat_ev = keep && (sat_hi || sat_lo);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stg_vld  <= 1'b0;
         stg_data <= '0;
      end else begin
         stg_vld <= keep;
         if (keep) begin
            stg_data <= q;
         end
      end
   end

   // ---------------------------------------------------------------
   // FWFT FIFO
   // ---------------------------------------------------------------
   logic [W_O-1:0] mem [DEPTH];
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [AW:0]    count;
   logic           full;
   logic           pop;
   logic           wr_ok;
   logic           drop;

   assign full    = (count == CNT_FULL);
   assign m_valid = (count != '0);
   assign pop     = m_valid && m_ready;
   // A pop on the same edge frees the slot for a full-FIFO write.
   assign wr_ok   = stg_vld && (!full || pop);
   assign drop    = stg_vld && full && !pop;
   assign m_data  = m_valid ? mem[rptr] : '0;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wptr] <= stg_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         unique case ({wr_ok, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Sticky flags; a set event outranks a clear in the same cycle
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sat_flag <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         if (sat_ev) begin
            sat_flag <= 1'b1;
         end else if (clr_flags) begin
            sat_flag <= 1'b0;
         end
         if (drop) begin
            ovf_flag <= 1'b1;
         end else if (clr_flags) begin
            ovf_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_out_requant.sv
// tb_fir_out_requant: directed and randomised checks of fir_out_requant
// against a queue-based behavioural model.
module tb_fir_out_requant;

   localparam int W_Y   = 10;
   localparam int W_O   = 4;
   localparam int SHIFT = 3;
   localparam int M     = 2;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic [W_Y-1:0] y = '0;
   logic           y_valid = 1'b0;
   logic [W_O-1:0] m_data;
   logic           m_valid;
   logic           m_ready = 1'b0;
   logic           clr_flags = 1'b0;
   logic           sat_flag;
   logic           ovf_flag;

   fir_out_requant #(
      .W_Y(W_Y), .W_O(W_O), .SHIFT(SHIFT), .M(M), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rstn(rstn), .y(y), .y_valid(y_valid),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .clr_flags(clr_flags), .sat_flag(sat_flag), .ovf_flag(ovf_flag)
   );

   always #5 clk = ~clk;

   int nt = 0;
   int nf = 0;
   bit cmp_en = 1'b0;

   // model state
   int mq[$];
   int got[$];
   int ph;
   bit stg_v;
   int stg_d;
   bit msat;
   bit movf;

   task automatic chk(string nm, int act, int exp);
      nt++;
      if (act != exp) begin
         nf++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // floor((v + 2^(SHIFT-1)) / 2^SHIFT), then clamp to W_O-bit range
   function automatic int rq(int v, output bit s);
      int half, d, t, r, mx, mn;
      half = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
      d = 1 << SHIFT;
      t = v + half;
      if (t >= 0) r = t / d;
      else r = -((-t + d - 1) / d);
      mx = (1 << (W_O - 1)) - 1;
      mn = -(1 << (W_O - 1));
      s = 1'b0;
      if (r > mx) begin r = mx; s = 1'b1; end
      if (r < mn) begin r = mn; s = 1'b1; end
      return r;
   endfunction

   task automatic model_reset();
      mq.delete();
      ph = 0;
      stg_v = 1'b0;
      stg_d = 0;
      msat = 1'b0;
      movf = 1'b0;
   endtask

   // one clock edge of the model, using inputs as sampled at that edge
   task automatic model_step();
      bit s, kept, sat_set, ovf_set, pp;
      int r;
      r = 0;
      s = 1'b0;
      pp = (mq.size() > 0) && m_ready;
      if (pp) void'(mq.pop_front());
      ovf_set = 1'b0;
      if (stg_v) begin
         if (mq.size() < DEPTH) mq.push_back(stg_d);
         else ovf_set = 1'b1;
      end
      kept = y_valid && (ph == 0);
      sat_set = 1'b0;
      if (kept) begin
         r = rq(int'($signed(y)), s);
         sat_set = s;
      end
      stg_v = kept;
      stg_d = r;
      if (y_valid) ph = (ph + 1) % M;
      msat = sat_set ? 1'b1 : (clr_flags ? 1'b0 : msat);
      movf = ovf_set ? 1'b1 : (clr_flags ? 1'b0 : movf);
   endtask

   task automatic cyc(int v, bit vv, bit rd, bit cl);
      y = W_Y'(v);
      y_valid = vv;
      m_ready = rd;
      clr_flags = cl;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle(int n, bit rd);
      for (int i = 0; i < n; i++) cyc(0, 1'b0, rd, 1'b0);
   endtask

   task automatic do_reset(bit chk_now);
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      if (chk_now) begin
         chk("rst_m_valid", m_valid, 0);
         chk("rst_m_data", int'($signed(m_data)), 0);
         chk("rst_sat", sat_flag, 0);
         chk("rst_ovf", ovf_flag, 0);
      end
      @(posedge clk);
      @(posedge clk);
      #2;
      rstn = 1'b1;
   endtask

   task automatic chk_got(string nm, int e[$]);
      chk({nm, "_cnt"}, got.size(), e.size());
      for (int i = 0; i < e.size() && i < got.size(); i++)
         chk(nm, got[i], e[i]);
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_valid", m_valid, int'(mq.size() > 0));
         if (mq.size() > 0)
            chk("m_data", int'($signed(m_data)), mq[0]);
         chk("sat_flag", sat_flag, msat);
         chk("ovf_flag", ovf_flag, movf);
         if (m_valid && m_ready) got.push_back(int'($signed(m_data)));
      end
   end

   initial begin
      int e[$];
      bit s;
      int v;

      model_reset();
      // pin the model's arithmetic
      chk("rq_20", rq(20, s), 3);
      chk("rq_m20", rq(-20, s), -2);
      chk("rq_12", rq(12, s), 2);
      chk("rq_m12", rq(-12, s), -1);
      chk("rq_100", rq(100, s), 7);
      chk("rq_100_sat", s, 1);
      chk("rq_m100", rq(-100, s), -8);

      @(posedge clk);
      #2;
      cmp_en = 1'b1;
      do_reset(1'b1);

      // rounding
      got.delete();
      foreach (e[i]) e.delete(i);
      e = '{20, -20, 12, -12, 0};
      foreach (e[i]) begin
         cyc(e[i], 1'b1, 1'b1, 1'b0);
         cyc(0, 1'b1, 1'b1, 1'b0);
      end
      idle(4, 1'b1);
      e = '{3, -2, 2, -1, 0};
      chk_got("round", e);
      chk("round_sat", sat_flag, 0);

      // saturation and clear
      got.delete();
      cyc(100, 1'b1, 1'b1, 1'b0);
      chk("sat_set", sat_flag, 1);
      cyc(0, 1'b1, 1'b1, 1'b0);
      cyc(-100, 1'b1, 1'b1, 1'b0);
      cyc(0, 1'b1, 1'b1, 1'b0);
      idle(4, 1'b1);
      e = '{7, -8};
      chk_got("sat", e);
      cyc(0, 1'b0, 1'b1, 1'b1);
      chk("sat_clr", sat_flag, 0);

      // decimation and latency
      do_reset(1'b0);
      got.delete();
      cyc(8, 1'b1, 1'b1, 1'b0);
      chk("lat_k", m_valid, 0);
      cyc(16, 1'b1, 1'b1, 1'b0);
      chk("lat_k1_valid", m_valid, 1);
      chk("lat_k1_data", int'($signed(m_data)), 1);
      cyc(24, 1'b1, 1'b1, 1'b0);
      cyc(32, 1'b1, 1'b1, 1'b0);
      idle(4, 1'b1);
      e = '{1, 3};
      chk_got("decim", e);

      // valid gaps
      do_reset(1'b0);
      got.delete();
      cyc(8, 1'b1, 1'b1, 1'b0);
      idle(3, 1'b1);
      cyc(16, 1'b1, 1'b1, 1'b0);
      cyc(40, 1'b1, 1'b1, 1'b0);
      idle(4, 1'b1);
      e = '{1, 5};
      chk_got("gaps", e);

      // backpressure, overflow, full-with-pop
      do_reset(1'b0);
      got.delete();
      e = '{8, 24, 40, 56, 72};
      foreach (e[i]) begin
         cyc(e[i], 1'b1, 1'b0, 1'b0);
         cyc(0, 1'b1, 1'b0, 1'b0);
      end
      idle(2, 1'b0);
      chk("bp_valid", m_valid, 1);
      chk("bp_head", int'($signed(m_data)), 1);
      chk("bp_ovf", ovf_flag, 1);
      cyc(-8, 1'b1, 1'b0, 1'b0);
      cyc(0, 1'b0, 1'b1, 1'b0);
      idle(8, 1'b1);
      e = '{1, 3, 5, 7, -1};
      chk_got("drain", e);
      chk("drain_empty", m_valid, 0);

      // reset mid-stream
      got.delete();
      cyc(8, 1'b1, 1'b0, 1'b0);
      cyc(0, 1'b1, 1'b0, 1'b0);
      cyc(24, 1'b1, 1'b0, 1'b0);
      cyc(0, 1'b1, 1'b0, 1'b0);
      cyc(100, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b0);
      chk("pre_rst_sat", sat_flag, 1);
      do_reset(1'b1);
      got.delete();
      cyc(16, 1'b1, 1'b1, 1'b0);
      idle(3, 1'b1);
      e = '{2};
      chk_got("post_rst", e);

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         v = int'($urandom_range(0, 1023)) - 512;
         cyc(v, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5,
             $urandom_range(0, 19) == 0);
      end
      idle(10, 1'b1);

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", nt, nf);
      $finish;
   end

endmodule
